// File: rtl/wb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_pkg - shared Wishbone widths and master FSM state type. Rev 1.0
// ------------------------------------------------------------------
package wb_pkg;

  localparam int WB_AW   = 30;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } master_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_timeout_ctr - counts enabled cycles, flags the LIMIT-th. Rev 1.0
// ------------------------------------------------------------------
module wb_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Count holds the number of earlier enabled cycles, so this is the LIMIT-th one.
  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_cmd_master - single-outstanding pipelined Wishbone command master.
// Optional bus timeout via WB_MASTER_TIMEOUT_EN. Rev 1.0
// ------------------------------------------------------------------
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_we,
  input  logic [WB_AW-1:0]   i_cmd_addr,
  input  logic [WB_DW-1:0]   i_cmd_data,
  input  logic [WB_SELW-1:0] i_cmd_sel,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [WB_DW-1:0]   o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  output logic               o_wb_we,
  output logic [WB_AW-1:0]   o_wb_addr,
  output logic [WB_DW-1:0]   o_wb_data,
  output logic [WB_SELW-1:0] o_wb_sel,
  input  logic               i_wb_ack,
  input  logic               i_wb_stall,
  input  logic               i_wb_err,
  input  logic [WB_DW-1:0]   i_wb_data
);

  master_state_t      state, state_n;
  logic               wb_cyc, wb_cyc_n, wb_stb, wb_stb_n, wb_we, wb_we_n;
  logic [WB_AW-1:0]   wb_addr, wb_addr_n;
  logic [WB_DW-1:0]   wb_data, wb_data_n;
  logic [WB_SELW-1:0] wb_sel, wb_sel_n;
  logic               rsp_valid, rsp_valid_n, rsp_err, rsp_err_n;
  logic [WB_DW-1:0]   rsp_data, rsp_data_n;
  logic               timeout, bus_take, bus_end;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (!wb_cyc),
    .enable  (wb_cyc),
    .expired (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign timeout            = 1'b0;
`endif

  // Slave replies only count once the strobe has been accepted (or afterwards).
  assign bus_take = (state == ST_WAIT) || ((state == ST_REQ) && !i_wb_stall);
  assign bus_end  = bus_take && (i_wb_ack || i_wb_err);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      wb_sel    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      wb_cyc    <= wb_cyc_n;
      wb_stb    <= wb_stb_n;
      wb_we     <= wb_we_n;
      wb_addr   <= wb_addr_n;
      wb_data   <= wb_data_n;
      wb_sel    <= wb_sel_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_err   <= rsp_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    wb_cyc_n    = wb_cyc;
    wb_stb_n    = wb_stb;
    wb_we_n     = wb_we;
    wb_addr_n   = wb_addr;
    wb_data_n   = wb_data;
    wb_sel_n    = wb_sel;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    rsp_err_n   = rsp_err;
    unique case (state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          state_n   = ST_REQ;
          wb_cyc_n  = 1'b1;
          wb_stb_n  = 1'b1;
          wb_we_n   = i_cmd_we;
          wb_addr_n = i_cmd_addr;
          wb_data_n = i_cmd_data;
          wb_sel_n  = i_cmd_sel;
        end
      end
      ST_REQ, ST_WAIT: begin
        if ((state == ST_REQ) && !i_wb_stall) begin
          state_n  = ST_WAIT;
          wb_stb_n = 1'b0;
        end
        if (bus_end) begin
          state_n     = ST_RESP;
          wb_cyc_n    = 1'b0;
          wb_stb_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = i_wb_err;
          rsp_data_n  = (i_wb_err || wb_we) ? '0 : i_wb_data;
        end else if (timeout) begin
          state_n     = ST_RESP;
          wb_cyc_n    = 1'b0;
          wb_stb_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_data_n  = '0;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_cmd_ready = (state == ST_IDLE);
  assign o_wb_cyc    = wb_cyc;
  assign o_wb_stb    = wb_stb;
  assign o_wb_we     = wb_we;
  assign o_wb_addr   = wb_addr;
  assign o_wb_data   = wb_data;
  assign o_wb_sel    = wb_sel;
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_data  = rsp_data;
  assign o_rsp_err   = rsp_err;

endmodule
`default_nettype wire

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameters, one per line:
- TIMEOUT_CYCLES, 64, cycles with o_wb_cyc high before abort; minimum 2.
REQ-002 Clock and reset: reset i_reset, synchronous, active-high; clock i_clk.
REQ-003 Ports, one per line (name  direction  width  meaning):
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_we  in  1  1=write, 0=read
- i_cmd_addr  in  30  word address
- i_cmd_data  in  32  write data
- i_cmd_sel  in  4  byte selects
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_data  out  32  read data (0 for writes)
- o_rsp_err  out  1  bus error or timeout
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone master controls
- o_wb_addr  out  30  bus address
- o_wb_data  out  32  bus write data
- o_wb_sel  out  4  bus byte selects
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses
- i_wb_data  in  32  slave read data

Function
REQ-004 FSM states: IDLE, REQ, WAIT, RESP; all Wishbone and rsp outputs registered.
REQ-005 o_cmd_ready SHALL be 1 only in IDLE; handshake latches we/addr/data/sel and enters REQ.
REQ-006 In REQ: o_wb_cyc=o_wb_stb=1 with latched fields held stable; a cycle with !i_wb_stall SHALL leave REQ, dropping o_wb_stb on the next cycle.
REQ-007 WAIT: o_wb_cyc=1, o_wb_stb=0, until i_wb_ack or i_wb_err.
REQ-008 i_wb_ack (in WAIT, or in REQ with !i_wb_stall) SHALL capture i_wb_data (reads), deassert o_wb_cyc next cycle, and enter RESP with o_rsp_err=0.
REQ-009 i_wb_err SHALL behave like ack but set o_rsp_err=1 and o_rsp_data=0; if ack and err coincide, err wins.
REQ-010 i_wb_ack/i_wb_err while o_wb_cyc=0 SHALL be ignored.
REQ-011 RESP: o_rsp_valid=1 with data/err stable until i_rsp_ready; then IDLE next cycle (no back-to-back command acceptance in RESP).
REQ-012 Latency: command accepted cycle 0, stb cycle 1, zero-stall slave ack in cycle 2, o_rsp_valid in cycle 3.
REQ-013 One transaction outstanding at most; o_wb_stb SHALL never assert while o_wb_cyc=0.

Reset
REQ-014 i_reset SHALL force IDLE next cycle: o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_addr/data/sel=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_cmd_ready=1 after reset releases.
REQ-015 Reset mid-transaction SHALL abandon the bus cycle (cyc drops) and discard any pending response without emitting it.

Configuration
REQ-016 Macro WB_MASTER_TIMEOUT_EN: defined, a counter SHALL count cycles with o_wb_cyc=1 (stall cycles included), and on reaching TIMEOUT_CYCLES with no ack/err the FSM SHALL drop cyc/stb and enter RESP with o_rsp_err=1, o_rsp_data=0.
REQ-017 Without WB_MASTER_TIMEOUT_EN no counter SHALL exist; REQ/WAIT wait indefinitely, and o_rsp_err derives solely from i_wb_err.

Structure
REQ-018 Shared package wb_pkg SHALL hold WB_AW=30, WB_DW=32, WB_SELW=4 and the master FSM state enum.
REQ-019 Timeout counting SHALL live in sub-module wb_timeout_ctr (clear/enable/expired), instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-020 Write: cmd we=1 addr=0x10 data=0xDEADBEEF sel=0xF, slave acks next cycle -> one stb cycle with those fields, o_rsp_valid cycle 3, o_rsp_err=0, o_rsp_data=0.
REQ-021 Read with i_wb_stall high 3 cycles, ack 2 cycles later with data 0x12345678 -> stb held 4 cycles with stable addr, o_rsp_data=0x12345678.
REQ-022 i_wb_err instead of ack on read -> o_rsp_err=1, o_rsp_data=0, cyc low next cycle.
REQ-023 Hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid and data stable, o_cmd_ready=0 throughout; IDLE one cycle after ready.
REQ-024 WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cyc cycles, o_rsp_err=1; late ack afterwards ignored.
REQ-025 i_reset asserted in WAIT -> cyc/stb 0 next cycle, no o_rsp_valid ever emitted for that command.
